keypad_scan: RTL

Memory-mapped 4x4 matrix-keypad reader, the CPU input counterpart to the write-only LED dot-matrix register. It drives the keypad columns one-hot active-low and samples the rows through a synchronizer. It debounces a full 16-key frame and queues press events in a 4-entry FIFO. The CPU reads the FIFO, which pops one event per read, over the same `conf_addr` bus the display register decodes.

---
 rtl/keypad_scan_if.sv | 14 +
 rtl/keypad_scan.sv | 118 +++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// CPU read bus plus keypad matrix pins for the keypad reader.
// master = CPU/board side, slave = keypad_scan.
interface keypad_scan_if;
  logic [31:0] conf_addr;
  logic        conf_rd;
  logic [31:0] conf_rdata;
  logic [3:0]  key_col;
  logic [3:0]  key_row;

  modport master (output conf_addr, output conf_rd, input conf_rdata,
                  input key_col, output key_row);
  modport slave  (input conf_addr, input conf_rd, output conf_rdata,
                  output key_col, input key_row);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, frame debounce, 4-deep press-event FIFO.
// Read data is registered (1-cycle latency); each matching read pops one event.
module keypad_scan #(
  parameter int          SCAN_DIV = 50000,
  parameter int          DEBOUNCE = 4,
  parameter logic [15:0] KEY_ADDR = 16'hf004
) (
  input logic          clk,
  input logic          resetn,
  keypad_scan_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [3:0]    sync1, sync2, rows;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col;
  logic [15:0]   raw, raw_next, prev_frame, deb_state, deb_next, new_press;
  logic [SW-1:0] stable_cnt;
  logic          tc, frame_end, frame_same, deb_load;

  logic [3:0]    fifo_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          ovf, empty, full, rd_hit, pop, push, push_ok, overflow;
  logic [3:0]    push_code;
  logic          unused_addr;

  assign unused_addr = ^bus.conf_addr[31:16];

  assign rows        = ~sync2;
  assign tc          = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end   = tc && (col == 2'd3);
  assign bus.key_col = ~(4'b0001 << col);

  always_comb begin
    raw_next = raw;
    if (tc) raw_next[{col, 2'b00} +: 4] = rows;
  end

  assign frame_same = (raw_next == prev_frame);
  assign deb_load   = frame_end && frame_same && (stable_cnt == SW'(DEBOUNCE - 1));
  assign deb_next   = deb_load ? raw_next : deb_state;
  assign new_press  = deb_next & ~deb_state;
  assign push       = |new_press;

  // Only the lowest-numbered new press is reported per debounce update.
  always_comb begin
    push_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (new_press[i]) push_code = 4'(i);
    end
  end

  assign empty    = (count == 3'd0);
  assign full     = (count == 3'd4);
  assign rd_hit   = bus.conf_rd && (bus.conf_addr[15:0] == KEY_ADDR);
  assign pop      = rd_hit && !empty;
  assign push_ok  = push && (!full || pop);
  assign overflow = push && full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1      <= 4'hf;
      sync2      <= 4'hf;
      div_cnt    <= '0;
      col        <= 2'd0;
      raw        <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
      deb_state  <= '0;
    end else begin
      sync1     <= bus.key_row;
      sync2     <= sync1;
      raw       <= raw_next;
      deb_state <= deb_next;
      if (tc) begin
        div_cnt <= '0;
        col     <= col + 2'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (frame_end) begin
        prev_frame <= raw_next;
        if (!frame_same) stable_cnt <= '0;
        else if (stable_cnt != SW'(DEBOUNCE - 1)) stable_cnt <= stable_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr         <= 2'd0;
      rd_ptr         <= 2'd0;
      count          <= 3'd0;
      ovf            <= 1'b0;
      bus.conf_rdata <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // A same-cycle overflow wins over the clear-on-read.
      ovf <= (rd_hit ? 1'b0 : ovf) | overflow;
      if (rd_hit)
        bus.conf_rdata <= {~empty, ovf, 10'b0, deb_state, empty ? 4'h0 : fifo_mem[rd_ptr]};
      else
        bus.conf_rdata <= '0;
    end
  end
endmodule
